// File: rtl/qar_i2c_pkg.sv
// Shared constants for the I2C controller and its pad-side line conditioner.
// Holds default filter/idle widths and the idle (released) bus level.
// No logic; imported by qar_i2c, qar_i2c_line_filter and qar_i2c_glitch_filter.
package qar_i2c_pkg;

  localparam int FILT_W_DEF      = 4;
  localparam int IDLE_W_DEF      = 10;
  localparam int IDLE_CYCLES_DEF = 1000;

  // Open-drain bus floats high when nobody drives it.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/qar_i2c_glitch_filter.sv
// Purpose: synchronise one raw I2C pad line and reject glitches of up to filt_cycles cycles.
// Latency: SYNC_STAGES + filt_cycles + 1 cycles from pad edge to f.
// Backpressure: none; free-running, output is a level.
module qar_i2c_glitch_filter
  import qar_i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FILT_W-1:0] filt_cycles,
  input  logic              pad,
  output logic              f
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt;
  logic                   sync_x;

  assign sync_x = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; keeps running even while the block is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Accept a new level only after it has differed from f for more than filt_cycles cycles.
  // The >= compare lets a lowered threshold take effect mid-count and keeps cnt from wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f   <= LINE_IDLE;
      cnt <= '0;
    end else if (!en) begin
      f   <= LINE_IDLE;
      cnt <= '0;
    end else if (sync_x == f) begin
      cnt <= '0;
    end else if (cnt >= filt_cycles) begin
      f   <= sync_x;
      cnt <= '0;
    end else begin
      cnt <= cnt + FILT_W'(1);
    end
  end

endmodule

// File: rtl/qar_i2c_line_filter.sv
// Purpose: filtered SCL/SDA plus SCL edge, START/rSTART/STOP, bus-busy and arbitration-lost flags.
// Latency: pulses are combinational from the filtered levels; bus_busy follows one cycle later.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module qar_i2c_line_filter
  import qar_i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int IDLE_W      = IDLE_W_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FILT_W-1:0] filt_cycles,
  input  logic              scl_pad,
  input  logic              sda_pad,
  input  logic              sda_drive_low,
  output logic              scl_f,
  output logic              sda_f,
  output logic              scl_rise,
  output logic              scl_fall,
  output logic              start_det,
  output logic              rstart_det,
  output logic              stop_det,
  output logic              bus_busy,
  output logic              arb_lost
);

  logic              scl_d;
  logic              sda_d;
  logic [IDLE_W-1:0] idle_cnt;
  logic              start_cond;
  logic              stop_cond;
  logic              idle_cond;
  logic              idle_hit;

  qar_i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_scl_filt (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .filt_cycles (filt_cycles),
    .pad         (scl_pad),
    .f           (scl_f)
  );

  qar_i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_sda_filt (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .filt_cycles (filt_cycles),
    .pad         (sda_pad),
    .f           (sda_f)
  );

  // Previous-cycle filtered levels; held idle while disabled so re-enable starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= LINE_IDLE;
      sda_d <= LINE_IDLE;
    end else if (!en) begin
      scl_d <= LINE_IDLE;
      sda_d <= LINE_IDLE;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SCL must be high in both cycles, so a simultaneous SCL/SDA change is neither START nor STOP.
  assign start_cond = en & scl_f & scl_d & sda_d & ~sda_f;
  assign stop_cond  = en & scl_f & scl_d & ~sda_d & sda_f;

  assign scl_rise   = en & scl_f & ~scl_d;
  assign scl_fall   = en & ~scl_f & scl_d;
  assign start_det  = start_cond & ~bus_busy;
  assign rstart_det = start_cond & bus_busy;
  assign stop_det   = stop_cond;
  // We released SDA but the line reads low at the sampling edge: another master won.
  assign arb_lost   = scl_rise & bus_busy & ~sda_drive_low & ~sda_f;

  assign idle_cond  = scl_f & sda_f & bus_busy;
  assign idle_hit   = idle_cond & (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));

  // Bus ownership tracking with an idle timeout for a master that vanished without a STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_busy <= 1'b0;
      idle_cnt <= '0;
    end else if (!en) begin
      bus_busy <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (start_cond) begin
        bus_busy <= 1'b1;
      end else if (stop_cond || idle_hit) begin
        bus_busy <= 1'b0;
      end
      if (idle_cond && !idle_hit) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule
